// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : shared widths and sweep FSM encoding for the shift sweep slice
// Revision  : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam int DATA_W = 4;
  localparam int AMT_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    OUT   = 2'd2
  } sweep_state_t;

endpackage

`default_nettype wire

// File: rtl/shift_operator.sv
// ============================================================================
// shift_operator : combinational logical left shift, truncated to DATA_W
// Revision       : 1.0
// ============================================================================
`default_nettype none

module shift_operator #(
  parameter int DATA_W = 4,
  parameter int AMT_W  = 2
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [AMT_W-1:0]  shift_amount,
  output logic [DATA_W-1:0] data_out
);

  assign data_out = data_in << shift_amount;

endmodule

`default_nettype wire

// File: rtl/shift_sweep_top.sv
// ============================================================================
// shift_sweep_top : sweep controller wrapped around the combinational shifter
// Revision        : 1.0
// ============================================================================
`default_nettype none

module shift_sweep_top #(
  parameter int DATA_W = shift_pkg::DATA_W,
  parameter int AMT_W  = shift_pkg::AMT_W,
  parameter int CNT_W  = shift_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AMT_W-1:0]  out_amt,
  output logic              out_last,
  output logic [CNT_W-1:0]  word_cnt
);

  logic [DATA_W-1:0] sh_data;
  logic [AMT_W-1:0]  sh_amt;
  logic [DATA_W-1:0] sh_result;

  shift_sweep_ctrl #(
    .DATA_W(DATA_W),
    .AMT_W (AMT_W),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sh_data  (sh_data),
    .sh_amt   (sh_amt),
    .sh_result(sh_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_amt  (out_amt),
    .out_last (out_last),
    .word_cnt (word_cnt)
  );

  shift_operator #(
    .DATA_W(DATA_W),
    .AMT_W (AMT_W)
  ) u_shift (
    .data_in     (sh_data),
    .shift_amount(sh_amt),
    .data_out    (sh_result)
  );

endmodule

`default_nettype wire

// File: rtl/shift_sweep_ctrl.sv
// ============================================================================
// shift_sweep_ctrl : sweeps one captured word through every shift amount and
//                    streams the registered results over valid/ready
// Revision         : 1.0
// ============================================================================
`default_nettype none

module shift_sweep_ctrl #(
  parameter int DATA_W = shift_pkg::DATA_W,
  parameter int AMT_W  = shift_pkg::AMT_W,
  parameter int CNT_W  = shift_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] sh_data,
  output logic [AMT_W-1:0]  sh_amt,
  input  logic [DATA_W-1:0] sh_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AMT_W-1:0]  out_amt,
  output logic              out_last,
  output logic [CNT_W-1:0]  word_cnt
);

  import shift_pkg::*;

  sweep_state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sh_data   <= '0;
      sh_amt    <= '0;
      out_data  <= '0;
      out_amt   <= '0;
      word_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sh_data  <= in_data;
            sh_amt   <= '0;
            in_ready <= 1'b0;
            state    <= DRIVE;
          end
        end
        // sh_data/sh_amt have been stable for a full cycle, so sh_result is settled here
        DRIVE: begin
          out_data  <= sh_result;
          out_amt   <= sh_amt;
          out_last  <= (sh_amt == {AMT_W{1'b1}});
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              word_cnt <= word_cnt + 1'b1;
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              sh_amt <= sh_amt + 1'b1;
              state  <= DRIVE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_sweep_ctrl.sv
// ============================================================================
// tb_shift_sweep_ctrl : scoreboard bench for the shift sweep controller
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_shift_sweep_ctrl;

  localparam int DATA_W = 4;
  localparam int AMT_W  = 2;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] sh_data;
  logic [AMT_W-1:0]  sh_amt;
  logic [DATA_W-1:0] sh_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [AMT_W-1:0]  out_amt;
  logic              out_last;
  logic [CNT_W-1:0]  word_cnt;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [AMT_W-1:0]  a;
    logic              l;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] exp_cnt = '0;

  always #5 clk = ~clk;

  // Shifter model in place of shift_operator
  assign sh_result = DATA_W'(sh_data << sh_amt);

  shift_sweep_ctrl #(
    .DATA_W(DATA_W),
    .AMT_W (AMT_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sh_data  (sh_data),
    .sh_amt   (sh_amt),
    .sh_result(sh_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_amt  (out_amt),
    .out_last (out_last),
    .word_cnt (word_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  function automatic logic [DATA_W-1:0] shl(input logic [DATA_W-1:0] d, input logic [AMT_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = d << a;
    return r;
  endfunction

  task automatic push_exp(input logic [DATA_W-1:0] d);
    exp_t e;
    for (int i = 0; i < (1 << AMT_W); i++) begin
      e.d = shl(d, AMT_W'(i));
      e.a = AMT_W'(i);
      e.l = (i == (1 << AMT_W) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_hand(input logic [DATA_W-1:0] d0, d1, d2, d3);
    exp_q.push_back('{d0, 2'd0, 1'b0});
    exp_q.push_back('{d1, 2'd1, 1'b0});
    exp_q.push_back('{d2, 2'd2, 1'b0});
    exp_q.push_back('{d3, 2'd3, 1'b1});
  endtask

  // Called at posedge+1; holds in_valid until the word is taken
  task automatic send(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin
        chk("cnt_at_accept", word_cnt, exp_cnt);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    timeout("send_accept");
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && in_ready) return;
    end
    timeout("drain");
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 50; t++) begin
      if (out_valid) return;
      @(posedge clk); #1;
    end
    timeout("wait_valid");
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold stability
  logic stall_prev = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        chk("hold_data", out_data, held.d);
        chk("hold_amt", out_amt, held.a);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_out: got data=%b amt=%0d with no result expected", out_data, out_amt);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_amt", out_amt, e.a);
          chk("out_last", out_last, e.l);
          if (e.l) exp_cnt = exp_cnt + 1'b1;
        end
      end
      stall_prev = out_valid && !out_ready;
      held = '{out_data, out_amt, out_last};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_sh_data", sh_data, 0);
    chk("rst_sh_amt", sh_amt, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Full sweep
    out_ready = 1'b1;
    push_hand(4'b1101, 4'b1010, 4'b0100, 4'b1000);
    send(4'b1101);
    chk("first_lat_drive", out_valid, 0);
    chk("busy_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("first_lat_valid", out_valid, 1);
    wait_drain();
    chk("sweep1_cnt", word_cnt, 1);
    chk("sweep1_in_ready", in_ready, 1);

    // Backpressure on amt1, with a reset glitch between edges
    out_ready = 1'b0;
    push_hand(4'b1101, 4'b1010, 4'b0100, 4'b1000);
    send(4'b1101);
    wait_valid();
    chk("bp_amt0", out_amt, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 4'b1010);
    chk("bp_amt", out_amt, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_gap", out_valid, 0);
    @(posedge clk); #1;
    chk("bp_rel_valid", out_valid, 1);
    chk("bp_rel_amt", out_amt, 2);
    wait_drain();
    chk("bp_cnt", word_cnt, 2);

    // Busy input: 0011 held high during a 1101 sweep
    push_hand(4'b1101, 4'b1010, 4'b0100, 4'b1000);
    push_hand(4'b0011, 4'b0110, 4'b1100, 4'b1000);
    send(4'b1101);
    send(4'b0011);
    wait_drain();
    chk("busy_cnt", word_cnt, 4);

    // Mid-sweep reset while presenting amt2
    out_ready = 1'b0;
    push_exp(4'b1101);
    send(4'b1101);
    for (int t = 0; t < 50; t++) begin
      if (out_valid && out_amt == 2'd2) break;
      out_ready = out_valid;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("mid_at_amt2", out_amt, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = '0;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_word_cnt", word_cnt, 0);
    chk("mid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Counter wrap over 256 words
    for (int i = 0; i < 256; i++) begin
      push_exp(DATA_W'(i * 7 + 1));
      send(DATA_W'(i * 7 + 1));
      if (i == 254) begin
        wait_drain();
        chk("cnt_255", word_cnt, 255);
      end
    end
    wait_drain();
    chk("cnt_wrap", word_cnt, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_sweep_ctrl.md
Name: shift_sweep_ctrl

Overview:
Sequential control stage placed directly upstream and downstream of the combinational shift_operator.
- Accepts one 4-bit word over a valid/ready input handshake.
- Drives that word into the shifter with every shift amount from 0 to 2^AMT_W-1 in turn.
- Registers each shifter result and presents it on a valid/ready output stream, tagged with the shift amount used.
- Converts the free-running combinational shifter into a flow-controlled pipeline stage.

Parameters:
DATA_W, 4, width of the data word and the shifter data path
AMT_W, 2, width of the shift amount; one sweep is 2^AMT_W results
CNT_W, 8, width of the completed-word counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
in_valid  in  1  upstream word available
in_ready  out  1  block can accept a word
in_data  in  DATA_W  word to sweep
sh_data  out  DATA_W  to shift_operator data_in
sh_amt  out  AMT_W  to shift_operator shift_amount
sh_result  in  DATA_W  from shift_operator data_out (combinational)
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  registered shifter result
out_amt  out  AMT_W  shift amount that produced out_data
out_last  out  1  high with the final result (out_amt = all ones) of a sweep
word_cnt  out  CNT_W  number of fully completed sweeps; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; in_ready=1; out_valid=0; out_last=0; sh_data, sh_amt, out_data, out_amt and word_cnt all 0. Reset is synchronous and active-low.
- Reset mid-sweep: the word in flight and any pending result are discarded with no output. word_cnt also clears.
- FSM states: IDLE, DRIVE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: sh_data<=in_data, sh_amt<=0, next state DRIVE.
  - in_data is captured, so upstream may change it after the handshake.
- DRIVE (exactly 1 cycle):
  - sh_data and sh_amt are stable registers, so sh_result settles within the cycle.
  - At the cycle end: out_data<=sh_result, out_amt<=sh_amt, out_last<=(sh_amt==all ones), out_valid<=1, next state OUT.
- OUT:
  - out_valid=1; out_data, out_amt and out_last hold stable until out_valid&out_ready.
  - On that handshake with out_last=0: sh_amt<=sh_amt+1, out_valid<=0, next state DRIVE.
  - On that handshake with out_last=1: out_valid<=0, word_cnt<=word_cnt+1, next state IDLE.
- in_ready=0 in DRIVE and OUT. in_valid is ignored while busy and must be held by upstream.
- Latency:
  - Input handshake to first out_valid: 2 cycles.
  - Each output handshake to the next out_valid: 2 cycles.
  - Minimum sweep length: 2*2^AMT_W cycles plus 1 IDLE cycle before the next word is accepted.
- out_ready asserted while out_valid=0 has no effect.
- out_ready held low stalls the block indefinitely with no loss of data.
- sh_amt never wraps within a sweep. The increment happens only when out_last=0.
- word_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Simultaneous in_valid and out handshake cannot occur, because in_ready=0 outside IDLE.

Decomposition:
- Shared package shift_pkg holds DATA_W, AMT_W, CNT_W defaults and the state encoding enum sweep_state_t (IDLE, DRIVE, OUT).
- No internal sub-module; the FSM and registers sit in one module.
- Integration wrapper shift_sweep_top instantiates shift_sweep_ctrl together with shift_operator.

Test Plan:
- Bench shifter model: data_out = data_in << shift_amount, logical, truncated to DATA_W.
- Reset: hold rst_n=0 for 2 clk, then release -> in_ready=1, out_valid=0, word_cnt=0; asynchronous glitches on rst_n between edges have no effect.
- Full sweep: in_data=4'b1101, out_ready=1 -> results 1101/amt0, 1010/amt1, 0100/amt2, 1000/amt3 with out_last only on amt3. word_cnt becomes 1 and in_ready returns to 1.
- Backpressure: out_ready=0 for 5 cycles on amt1 -> out_data=1010 and out_amt=1 stay stable. Release gives amt2 two cycles later with no result skipped or duplicated.
- Busy input: in_valid held high with 4'b0011 during a 4'b1101 sweep -> 0011 is accepted only in IDLE after the sweep. Its sweep yields 0011, 0110, 1100, 1000.
- Mid-sweep reset: rst_n=0 for one edge while in OUT with amt2 -> out_valid=0, word_cnt=0 next cycle, and no amt3 result appears.
- Counter wrap: 256 back-to-back words -> word_cnt returns to 0.
